// File: rtl/hdng_err_gen.sv
// rtl/hdng_err_gen.sv - wrapped, saturated heading error with settle detection
module hdng_err_gen #(
   parameter int SETTLE_CNT    = 8,
   parameter int SETTLE_THRESH = 30
) (
   input  logic              clk,
   input  logic              rst,
   input  logic signed [11:0] heading,
   input  logic              hdng_vld,
   input  logic signed [11:0] dsrd_hdng,
   input  logic              moving,
   output logic signed [9:0] err_sat,
   output logic              err_vld,
   output logic              at_hdng
);

   localparam logic [7:0]  CNT_MAX = 8'(SETTLE_CNT);
   localparam logic [10:0] THRESH  = 11'(SETTLE_THRESH);

   logic signed [11:0] err_raw;
   logic signed [11:0] dsrd_q;
   logic               s1_vld;
   logic               tgt_chg;
   logic               tgt_q;
   logic [7:0]         cnt;
   logic [7:0]         cnt_nxt;
   logic signed [9:0]  clamp_val;
   logic [10:0]        mag;

   always_comb begin
      clamp_val = err_raw[9:0];
      if (err_raw > 12'sd511)
         clamp_val = 10'sd511;
      else if (err_raw < -12'sd512)
         clamp_val = 10'b10_0000_0000;
   end

   // 11-bit magnitude so that -512 maps to 512 and never passes the threshold
   always_comb begin
      mag = {err_sat[9], err_sat};
      if (err_sat[9])
         mag = 11'd0 - {err_sat[9], err_sat};
   end

   always_comb begin
      cnt_nxt = cnt;
      if (err_vld) begin
         if (!moving || tgt_q)
            cnt_nxt = 8'd0;
         else if (mag <= THRESH)
            cnt_nxt = (cnt >= CNT_MAX) ? CNT_MAX : cnt + 8'd1;
         else
            cnt_nxt = 8'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         err_raw <= '0;
         dsrd_q  <= '0;
         s1_vld  <= 1'b0;
         tgt_chg <= 1'b0;
         tgt_q   <= 1'b0;
         err_sat <= '0;
         err_vld <= 1'b0;
         cnt     <= '0;
         at_hdng <= 1'b0;
      end else begin
         s1_vld <= hdng_vld;
         if (hdng_vld) begin
            err_raw <= heading - dsrd_hdng;
            dsrd_q  <= dsrd_hdng;
            tgt_chg <= (dsrd_hdng != dsrd_q);
         end
         err_vld <= s1_vld;
         if (s1_vld) begin
            err_sat <= clamp_val;
            tgt_q   <= tgt_chg;
         end
         cnt     <= cnt_nxt;
         // Look-ahead on cnt_nxt so at_hdng follows the sample one edge after err_vld
         at_hdng <= moving && (cnt_nxt == CNT_MAX);
      end
   end

endmodule

// File: tb/tb_hdng_err_gen.sv
// tb/tb_hdng_err_gen.sv - scoreboard bench for hdng_err_gen
module tb_hdng_err_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic [11:0] heading;
   logic        hdng_vld;
   logic [11:0] dsrd_hdng;
   logic        moving;
   logic [9:0]  err_sat;
   logic        err_vld;
   logic        at_hdng;

   int total = 0;
   int bad   = 0;

   typedef struct {
      int err;
      bit at;
   } exp_t;

   exp_t q[$];
   int   m_dsrd = 0;
   int   m_cnt  = 0;
   bit   at_pend = 0;
   bit   at_exp  = 0;

   hdng_err_gen #(.SETTLE_CNT(8), .SETTLE_THRESH(30)) dut (
      .clk(clk), .rst(rst), .heading(heading), .hdng_vld(hdng_vld),
      .dsrd_hdng(dsrd_hdng), .moving(moving), .err_sat(err_sat),
      .err_vld(err_vld), .at_hdng(at_hdng)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int ref_err(input int h, input int d);
      int e;
      e = (h - d) & 4095;
      if (e >= 2048) e -= 4096;
      if (e > 511) e = 511;
      if (e < -512) e = -512;
      return e;
   endfunction

   task automatic send(input int h, input int d);
      exp_t x;
      int   e;
      bit   tgt;
      e   = ref_err(h, d);
      tgt = ((d & 4095) != m_dsrd);
      m_dsrd = d & 4095;
      if (!moving || tgt) m_cnt = 0;
      else if ((e < 0 ? -e : e) <= 30) m_cnt = (m_cnt < 8) ? m_cnt + 1 : 8;
      else m_cnt = 0;
      x.err = e;
      x.at  = moving && (m_cnt == 8);
      q.push_back(x);
      heading   = h[11:0];
      dsrd_hdng = d[11:0];
      hdng_vld  = 1'b1;
      @(posedge clk); #1;
      hdng_vld  = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((q.size() != 0 || at_pend) && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (q.size() != 0 || at_pend) check("drain_timeout", q.size(), 0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (at_pend) begin
         check("at_hdng", int'(at_hdng), int'(at_exp));
         at_pend = 0;
      end
      if (err_vld) begin
         if (q.size() == 0) begin
            check("unexpected_err_vld", 1, 0);
         end else begin
            exp_t x;
            x = q.pop_front();
            check("err_sat", int'($signed(err_sat)), x.err);
            at_exp  = x.at;
            at_pend = 1;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      int d;
      int h;
      rst = 1'b1; hdng_vld = 1'b0; heading = '0; dsrd_hdng = '0; moving = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_err_sat", int'(err_sat), 0);
      check("rst_err_vld", int'(err_vld), 0);
      check("rst_at_hdng", int'(at_hdng), 0);
      @(posedge clk); #1;
      rst = 1'b0;

      send(12'h100, 0);
      wait_idle();
      check("held_err_sat", int'($signed(err_sat)), 256);
      check("held_err_vld", int'(err_vld), 0);

      send(12'h7FF, 12'h800);
      send(12'h800, 12'h7FF);
      send(12'h600, 0);
      send(12'hA00, 0);
      send(12'h1FF, 0);
      wait_idle();

      moving = 1'b1;
      repeat (8) send(10, 0);
      wait_idle();
      check("settled", int'(at_hdng), 1);
      send(40, 0);
      send(-30, 0);
      repeat (7) send(-30, 0);
      wait_idle();
      check("settled_neg", int'(at_hdng), 1);
      send(5, 5);
      repeat (8) send(5, 5);
      wait_idle();
      moving = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("moving_drop", int'(at_hdng), 0);
      #1;
      send(5, 5);
      wait_idle();
      moving = 1'b1;

      for (int i = 0; i < 10; i++) send(500 + 3 * i, 0);
      wait_idle();

      d = 0;
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 19) == 0) d = int'($urandom_range(0, 4095));
         if ($urandom_range(0, 9) == 0) h = int'($urandom_range(0, 4095));
         else h = d + int'($urandom_range(0, 80)) - 40;
         send(h, d);
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
      end
      wait_idle();

      heading = 12'h100; dsrd_hdng = 12'h123; hdng_vld = 1'b1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; hdng_vld = 1'b0;
      m_dsrd = 0; m_cnt = 0;
      @(negedge clk);
      check("mid_rst_err_sat", int'(err_sat), 0);
      check("mid_rst_err_vld", int'(err_vld), 0);
      check("mid_rst_at_hdng", int'(at_hdng), 0);
      repeat (5) @(posedge clk);
      #1;
      send(3, 0);
      wait_idle();
      check("queue_empty", q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/hdng_err_gen.md
# hdng_err_gen

Heading-error front end for the PID controller. It samples measured heading against desired heading on each valid gyro sample and computes a wrapped angular error. It saturates that error to 10 bits and presents it as `err_sat`/`err_vld` directly to the integrator (I_term) and the P/D stages. It also runs a settle counter that flags when the heading has stayed within tolerance for a programmable number of consecutive samples.

## Interface
- `SETTLE_CNT`, default 8: consecutive in-tolerance samples required to assert `at_hdng` (range 1..255).
- `SETTLE_THRESH`, default 30: tolerance bound on |err_sat|; a sample counts when |err_sat| ≤ SETTLE_THRESH.
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `heading`  in  12  signed measured heading; full 12-bit range = one revolution.
- `hdng_vld`  in  1  single-cycle strobe; `heading` and `dsrd_hdng` are valid this cycle.
- `dsrd_hdng`  in  12  signed desired heading.
- `moving`  in  1  high while the platform is commanded to move.
- `err_sat`  out  10  signed saturated heading error.
- `err_vld`  out  1  one-cycle strobe; `err_sat` holds a new sample.
- `at_hdng`  out  1  level; heading has settled within tolerance.

## Operation
- Stage 1, on edge with `hdng_vld`=1:
  - `err_raw` = (heading − dsrd_hdng) mod 2^12, interpreted as 12-bit signed. Natural two's-complement wrap gives the shortest-path angle, and no 13th bit is kept.
  - `dsrd_hdng` is also captured into `dsrd_q`, and a `tgt_chg` flag is set if it differs from the previous `dsrd_q`.
- Stage 2, one edge later:
  - `err_sat` = clamp(err_raw, −512, +511).
  - `err_vld` pulses for one cycle.
  - Stage 2 updates only when the stage-1 valid bit is set. Otherwise `err_sat` holds its last value.
- Settle counter, 8 bits, evaluated on the edge after each `err_vld`, in priority order:
  1. `moving`=0 or `tgt_chg` (of that sample): clear to 0.
  2. |err_sat| ≤ SETTLE_THRESH: increment, saturating at SETTLE_CNT.
  3. Otherwise: clear to 0.
- `at_hdng` is registered and equals (count == SETTLE_CNT) when `moving`=1. It is forced 0 on the edge after `moving` falls, regardless of `err_vld`.
- Magnitude for the threshold test is taken on the 10-bit value. −512 yields 512 and never passes.

## Timing
- Reset (rst=1 on an edge): `err_sat`=0, `err_vld`=0, `at_hdng`=0. The counter, `dsrd_q`, stage-1 error and stage-1 valid are all cleared.
- Reset mid-pipeline discards in-flight samples; no `err_vld` is emitted for a sample accepted before reset.
- `hdng_vld` sampled at edge k → `err_sat`/`err_vld`=1 visible after edge k+1 (latency 1 cycle from sample edge, 2 register stages).
- `at_hdng` reflects that sample after edge k+2.
- Back-to-back `hdng_vld` every cycle is supported: full throughput, `err_vld` high on consecutive cycles, no stalls, no backpressure.
- The first sample after reset compares against `dsrd_q`=0. It sets `tgt_chg` if `dsrd_hdng`≠0.
- `moving` and `err_vld` changing on the same edge: the `moving` value at that edge governs, and a clear wins over an increment.
- `hdng_vld` asserted while rst=1 is ignored.

## Test plan
- Basic error:
  - Stimulus: heading=12'h100, dsrd_hdng=0, one `hdng_vld` pulse.
  - Response: after the next edge, err_sat=+256 with err_vld=1 for exactly one cycle, then err_vld=0 and err_sat held.
- Wrap:
  - Case 1: heading=12'h7FF, dsrd_hdng=12'h800 → err_sat=−1 (10'h3FF).
  - Case 2: heading=12'h800, dsrd_hdng=12'h7FF → err_sat=+1.
- Saturation:
  - heading=12'h600, dsrd=0 → err_sat=+511.
  - heading=12'hA00, dsrd=0 → err_sat=−512.
  - heading=12'h1FF, dsrd=0 → err_sat=+511 (boundary, unclipped).
- Settle:
  - Setup: moving=1, dsrd=0 held, 8 samples with heading=10.
  - Required: at_hdng=0 through the 7th sample and 1 one cycle after the 8th err_vld.
  - Then a sample with heading=40 drops at_hdng to 0, and a sample with heading=−30 counts as in tolerance.
- Clears:
  - With at_hdng=1, changing dsrd_hdng to 5 (heading 5) clears at_hdng on that sample's update.
  - With at_hdng=1, dropping `moving` clears at_hdng on the next edge with no `hdng_vld`.
- Throughput and reset:
  - Ten consecutive `hdng_vld` cycles with incrementing heading → ten consecutive err_vld cycles with matching err_sat sequence.
  - rst=1 asserted the cycle after a `hdng_vld` → no err_vld, and err_sat=0, at_hdng=0.
